// File: rtl/decode_issue_ctrl.sv
// Decode-to-execute issue controller: one-entry issue register with load scoreboard,
// control-transfer/illegal blocking, and a saturating stall counter.
// Latency: 1 cycle from input to output.
// Backpressure: in_ready drops on a hazard, on flush, or when the issue register is full
// and execute does not take it.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     decoder handshake; in_pc, in_inst, decode flags
//   out_valid/out_ready   execute handshake; out_pc, out_inst, out_illegal
//   wb_valid, wb_rd       load writeback, clears scoreboard entry
//   br_resolve            pending control transfer resolved without redirect
//   flush                 redirect/trap, discards the held instruction
//   stall_cnt             saturating count of cycles with in_valid & ~in_ready
module decode_issue_ctrl #(
  parameter int XLEN  = 64,
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_inst,
  input  logic             in_rs1_en,
  input  logic             in_rs2_en,
  input  logic             in_rd_en,
  input  logic             in_mem_read,
  input  logic             in_ctrl,
  input  logic             in_illegal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [31:0]      out_inst,
  output logic             out_illegal,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             br_resolve,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            ctrl_pend;
  logic            out_mem_read;
  logic            out_rd_en;

  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic [4:0] held_rd;
  logic       hazard;
  logic       in_fire;
  logic       out_fire;
  logic       held_load_dropped;

  assign rs1     = in_inst[19:15];
  assign rs2     = in_inst[24:20];
  assign rd      = in_inst[11:7];
  assign held_rd = out_inst[11:7];

  // The rd check catches WAW against an in-flight load so a later writer
  // cannot be overwritten by the older load's writeback.
  assign hazard = (in_rs1_en & busy[rs1])
                | (in_rs2_en & busy[rs2])
                | (in_rd_en  & busy[rd])
                | ctrl_pend;

  assign in_ready = ~rst & ~flush & ~hazard & (~out_valid | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ~flush;

  // A flushed load never reaches execute, so nothing will write it back.
  assign held_load_dropped = flush & out_valid & out_mem_read & out_rd_en;

  // Issue register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_inst     <= '0;
      out_illegal  <= 1'b0;
      out_mem_read <= 1'b0;
      out_rd_en    <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (in_fire) begin
        out_valid    <= 1'b1;
        out_pc       <= in_pc;
        out_inst     <= in_inst;
        out_illegal  <= in_illegal;
        out_mem_read <= in_mem_read;
        out_rd_en    <= in_rd_en;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Scoreboard: clears first, then the set, so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) begin
      busy_nxt[wb_rd] = 1'b0;
    end
    if (held_load_dropped) begin
      busy_nxt[held_rd] = 1'b0;
    end
    if (in_fire & in_mem_read & in_rd_en) begin
      busy_nxt[rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Control/illegal blocking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_pend <= 1'b0;
    end else if (flush) begin
      ctrl_pend <= 1'b0;
    end else if (in_fire & (in_ctrl | in_illegal)) begin
      ctrl_pend <= 1'b1;
    end else if (br_resolve) begin
      ctrl_pend <= 1'b0;
    end
  end

  // Stall counter, saturating, survives flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid & ~in_ready & ~flush & ~(&stall_cnt)) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: inputs driven on the falling edge,
// outputs checked after the falling edge.
module tb_decode_issue_ctrl;

  localparam int XLEN  = 64;
  localparam int CNT_W = 32;

  // flag order: rs1_en rs2_en rd_en mem_read ctrl illegal
  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_LD   = 6'b101100;
  localparam logic [5:0] F_LD0  = 6'b001100;
  localparam logic [5:0] F_RRR  = 6'b111000;
  localparam logic [5:0] F_R1RD = 6'b101000;
  localparam logic [5:0] F_RR   = 6'b110000;
  localparam logic [5:0] F_BR   = 6'b110010;
  localparam logic [5:0] F_JAL  = 6'b001010;
  localparam logic [5:0] F_ILL  = 6'b000001;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [31:0]      in_inst;
  logic             in_rs1_en, in_rs2_en, in_rd_en, in_mem_read, in_ctrl, in_illegal;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [31:0]      out_inst;
  logic             out_illegal;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             br_resolve;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;

  int vecs = 0;
  int errs = 0;
  logic [CNT_W-1:0] exp_stall = '0;

  decode_issue_ctrl #(.XLEN(XLEN), .NREG(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en), .in_rd_en(in_rd_en),
    .in_mem_read(in_mem_read), .in_ctrl(in_ctrl), .in_illegal(in_illegal),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .br_resolve(br_resolve), .flush(flush),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  task automatic drv(input logic v, input logic [XLEN-1:0] pc, input logic [31:0] inst, input logic [5:0] f);
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst;
    {in_rs1_en, in_rs2_en, in_rd_en, in_mem_read, in_ctrl, in_illegal} = f;
  endtask

  task automatic test_reset;
    drv(1'b1, 64'h55, mk(1, 2, 3), F_RRR);
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    vecs++; if (out_pc !== 64'h0) begin errs++; $display("FAIL rst_out_pc got %h want 0", out_pc); end
    vecs++; if (out_inst !== 32'h0) begin errs++; $display("FAIL rst_out_inst got %h want 0", out_inst); end
    vecs++; if (out_illegal !== 1'b0) begin errs++; $display("FAIL rst_out_illegal got %b want 0", out_illegal); end
    vecs++; if (stall_cnt !== '0) begin errs++; $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_load_use;
    @(negedge clk); drv(1'b1, 64'h100, mk(5, 1, 0), F_LD); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL lu_ld_ready got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_pc !== 64'h100 || out_valid !== 1'b1) begin errs++; $display("FAIL lu_ld_out got pc=%h v=%b want pc=100 v=1", out_pc, out_valid); end
    vecs++; if (out_inst !== mk(5, 1, 0)) begin errs++; $display("FAIL lu_ld_inst got %h want %h", out_inst, mk(5, 1, 0)); end
    drv(1'b1, 64'h104, mk(6, 5, 1), F_RRR); #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL lu_add_stall got %b want 0", in_ready); end
    @(negedge clk); exp_stall = 1;
    vecs++; if (stall_cnt !== exp_stall) begin errs++; $display("FAIL lu_stall1 got %0d want %0d", stall_cnt, exp_stall); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL lu_drain got %b want 0", out_valid); end
    @(negedge clk); exp_stall = 2;
    vecs++; if (stall_cnt !== exp_stall) begin errs++; $display("FAIL lu_stall2 got %0d want %0d", stall_cnt, exp_stall); end
    wb_valid = 1'b1; wb_rd = 5'd5; #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL lu_no_bypass got %b want 0", in_ready); end
    @(negedge clk); exp_stall = 3; wb_valid = 1'b0;
    vecs++; if (stall_cnt !== exp_stall) begin errs++; $display("FAIL lu_stall3 got %0d want %0d", stall_cnt, exp_stall); end
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL lu_after_wb got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_pc !== 64'h104 || stall_cnt !== exp_stall) begin errs++; $display("FAIL lu_add_out got pc=%h cnt=%0d want pc=104 cnt=%0d", out_pc, stall_cnt, exp_stall); end
    in_valid = 1'b0;
  endtask

  task automatic test_collision;
    @(negedge clk); drv(1'b1, 64'h110, mk(7, 2, 0), F_LD); wb_valid = 1'b1; wb_rd = 5'd7; #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL col_ld_ready got %b want 1", in_ready); end
    @(negedge clk); wb_valid = 1'b0; drv(1'b1, 64'h114, mk(8, 7, 0), F_R1RD); #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL col_set_wins got %b want 0", in_ready); end
    @(negedge clk); exp_stall = 4;
    vecs++; if (stall_cnt !== exp_stall) begin errs++; $display("FAIL col_stall4 got %0d want %0d", stall_cnt, exp_stall); end
    wb_valid = 1'b1; wb_rd = 5'd7; #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL col_wb_cycle got %b want 0", in_ready); end
    @(negedge clk); exp_stall = 5; wb_valid = 1'b0;
    vecs++; if (stall_cnt !== exp_stall) begin errs++; $display("FAIL col_stall5 got %0d want %0d", stall_cnt, exp_stall); end
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL col_release got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_pc !== 64'h114) begin errs++; $display("FAIL col_out_pc got %h want 114", out_pc); end
    in_valid = 1'b0;
  endtask

  task automatic test_x0;
    @(negedge clk); drv(1'b1, 64'h120, mk(0, 0, 0), F_LD0); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL x0_ld_ready got %b want 1", in_ready); end
    @(negedge clk); drv(1'b1, 64'h124, mk(0, 0, 0), F_RR); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL x0_never_busy got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_pc !== 64'h124) begin errs++; $display("FAIL x0_out_pc got %h want 124", out_pc); end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    @(negedge clk); out_ready = 1'b0; drv(1'b1, 64'h200, mk(10, 0, 0), F_NONE); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_first_ready got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_pc !== 64'h200 || out_valid !== 1'b1) begin errs++; $display("FAIL bp_a_out got pc=%h v=%b want pc=200 v=1", out_pc, out_valid); end
    drv(1'b1, 64'h204, mk(11, 0, 0), F_NONE); #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_full got %b want 0", in_ready); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vecs++; if (out_pc !== 64'h200 || out_inst !== mk(10, 0, 0)) begin errs++; $display("FAIL bp_hold%0d got pc=%h inst=%h want pc=200", i, out_pc, out_inst); end
    end
    @(negedge clk); exp_stall = 8;
    vecs++; if (stall_cnt !== exp_stall) begin errs++; $display("FAIL bp_stall got %0d want %0d", stall_cnt, exp_stall); end
    out_ready = 1'b1; #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_resume got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_pc !== 64'h204 || out_valid !== 1'b1) begin errs++; $display("FAIL bp_b_out got pc=%h v=%b want pc=204 v=1", out_pc, out_valid); end
    drv(1'b1, 64'h208, mk(12, 0, 0), F_NONE); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_b2b got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_pc !== 64'h208 || stall_cnt !== exp_stall) begin errs++; $display("FAIL bp_c_out got pc=%h cnt=%0d want pc=208 cnt=%0d", out_pc, stall_cnt, exp_stall); end
    in_valid = 1'b0;
    @(negedge clk);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_branch;
    @(negedge clk); drv(1'b1, 64'h300, mk(0, 1, 2), F_BR); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL br_beq_ready got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_pc !== 64'h300) begin errs++; $display("FAIL br_beq_out got %h want 300", out_pc); end
    drv(1'b1, 64'h304, mk(11, 0, 0), F_NONE); #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL br_blocked got %b want 0", in_ready); end
    @(negedge clk);
    @(negedge clk); exp_stall = 10;
    vecs++; if (stall_cnt !== exp_stall) begin errs++; $display("FAIL br_stall got %0d want %0d", stall_cnt, exp_stall); end
    br_resolve = 1'b1; #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL br_resolve_cycle got %b want 0", in_ready); end
    @(negedge clk); exp_stall = 11; br_resolve = 1'b0; #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL br_resolved got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_pc !== 64'h304) begin errs++; $display("FAIL br_next_out got %h want 304", out_pc); end
    drv(1'b1, 64'h400, mk(1, 0, 0), F_JAL); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL br_jal_ready got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_pc !== 64'h400 || out_valid !== 1'b1) begin errs++; $display("FAIL br_jal_out got pc=%h v=%b want pc=400 v=1", out_pc, out_valid); end
    out_ready = 1'b0; drv(1'b1, 64'h404, mk(12, 0, 0), F_NONE); flush = 1'b1; #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL br_flush_ready got %b want 0", in_ready); end
    @(negedge clk); flush = 1'b0;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL br_jal_dropped got %b want 0", out_valid); end
    vecs++; if (stall_cnt !== exp_stall) begin errs++; $display("FAIL br_flush_nocount got %0d want %0d", stall_cnt, exp_stall); end
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL br_after_flush got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_pc !== 64'h404 || out_valid !== 1'b1) begin errs++; $display("FAIL br_after_out got pc=%h v=%b want pc=404 v=1", out_pc, out_valid); end
    out_ready = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_illegal;
    @(negedge clk); drv(1'b1, 64'h500, 32'hFFFF_FFFF, F_ILL); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL ill_ready got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_illegal !== 1'b1 || out_inst !== 32'hFFFF_FFFF) begin errs++; $display("FAIL ill_out got ill=%b inst=%h want ill=1 inst=ffffffff", out_illegal, out_inst); end
    drv(1'b1, 64'h504, mk(13, 0, 0), F_NONE); #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL ill_blocks got %b want 0", in_ready); end
    @(negedge clk); exp_stall = 12;
    vecs++; if (stall_cnt !== exp_stall) begin errs++; $display("FAIL ill_stall got %0d want %0d", stall_cnt, exp_stall); end
    flush = 1'b1; in_valid = 1'b0;
    @(negedge clk); flush = 1'b0; drv(1'b1, 64'h508, mk(13, 0, 0), F_NONE); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL ill_flush_clears got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_illegal !== 1'b0 || out_pc !== 64'h508) begin errs++; $display("FAIL ill_next_out got ill=%b pc=%h want ill=0 pc=508", out_illegal, out_pc); end
    in_valid = 1'b0;
  endtask

  task automatic test_flush_load;
    @(negedge clk); drv(1'b1, 64'h600, mk(3, 0, 0), F_LD0); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL fl_ld3_ready got %b want 1", in_ready); end
    @(negedge clk); drv(1'b1, 64'h604, mk(9, 0, 0), F_LD0); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL fl_ld9_ready got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_pc !== 64'h604) begin errs++; $display("FAIL fl_ld9_out got %h want 604", out_pc); end
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b0;
    @(negedge clk); flush = 1'b0;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL fl_dropped got %b want 0", out_valid); end
    drv(1'b1, 64'h608, mk(14, 9, 0), F_R1RD); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL fl_x9_free got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_pc !== 64'h608) begin errs++; $display("FAIL fl_x9_out got %h want 608", out_pc); end
    out_ready = 1'b1; drv(1'b1, 64'h60c, mk(15, 3, 0), F_R1RD); #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL fl_x3_busy got %b want 0", in_ready); end
    @(negedge clk); exp_stall = 13;
    vecs++; if (stall_cnt !== exp_stall) begin errs++; $display("FAIL fl_stall got %0d want %0d", stall_cnt, exp_stall); end
    wb_valid = 1'b1; wb_rd = 5'd3;
    @(negedge clk); wb_valid = 1'b0; exp_stall = 14; #1;
    vecs++; if (in_ready !== 1'b1 || stall_cnt !== exp_stall) begin errs++; $display("FAIL fl_x3_wb got rdy=%b cnt=%0d want rdy=1 cnt=%0d", in_ready, stall_cnt, exp_stall); end
    @(negedge clk);
    vecs++; if (out_pc !== 64'h60c) begin errs++; $display("FAIL fl_x3_out got %h want 60c", out_pc); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk); out_ready = 1'b0; drv(1'b1, 64'h700, mk(5, 0, 0), F_LD0); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rm_ld_ready got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL rm_held got %b want 1", out_valid); end
    #2 rst = 1'b1; #1;
    vecs++; if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_inst !== 32'h0) begin errs++; $display("FAIL rm_async got v=%b pc=%h inst=%h want all 0", out_valid, out_pc, out_inst); end
    vecs++; if (stall_cnt !== '0 || in_ready !== 1'b0) begin errs++; $display("FAIL rm_cnt_ready got cnt=%0d rdy=%b want 0 0", stall_cnt, in_ready); end
    @(negedge clk);
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rm_hold_ready got %b want 0", in_ready); end
    rst = 1'b0; out_ready = 1'b1; drv(1'b1, 64'h704, mk(6, 5, 0), F_R1RD); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rm_busy_cleared got %b want 1", in_ready); end
    @(negedge clk);
    vecs++; if (out_pc !== 64'h704 || stall_cnt !== '0) begin errs++; $display("FAIL rm_after got pc=%h cnt=%0d want pc=704 cnt=0", out_pc, stall_cnt); end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drv(1'b0, '0, '0, F_NONE);
    out_ready  = 1'b1;
    wb_valid   = 1'b0;
    wb_rd      = 5'd0;
    br_resolve = 1'b0;
    flush      = 1'b0;
    test_reset;
    test_load_use;
    test_collision;
    test_x0;
    test_backpressure;
    test_branch;
    test_illegal;
    test_flush_load;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
